q_meter: RTL and testbench
==========================

Q_METER -- requirements
Module: q_meter

Interface
REQ-001 SHALL have parameter WIDTH, default 10: bit width of samples, i_ref_setup and q_measured.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: clk cycles to wait after a bias change before measuring.
REQ-003 SHALL have parameter WIN_LEN, default 32: accepted samples per peak-to-peak window.
REQ-004 SHALL have parameter LOG2_AVG, default 2: log2 of the number of windows averaged per report.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port sample, input, WIDTH: unsigned oscillator amplitude sample.
REQ-008 SHALL have port sample_valid, input, 1: sample is accepted on a rising clk edge while this is high.
REQ-009 SHALL have port i_ref_setup, input, WIDTH: current bias code from the instability detector.
REQ-010 SHALL have port q_measured, output, WIDTH: averaged peak-to-peak amplitude, registered.
REQ-011 SHALL have port ready, output, 1: one-cycle pulse, q_measured updated this cycle.
REQ-012 SHALL have port overrange, output, 1: sticky clip flag (see Configuration).

Function
REQ-013 SHALL implement FSM states SETTLE, MEASURE, REPORT.
REQ-014 SETTLE SHALL count clk cycles, independent of sample_valid, and move to MEASURE after SETTLE_CYCLES cycles.
REQ-015 MEASURE SHALL track per-window max/min; the first accepted sample of a window loads both.
REQ-016 At the WIN_LEN-th accepted sample, max-min SHALL be added to an accumulator WIDTH+LOG2_AVG bits wide (no overflow possible), and the window SHALL restart.
REQ-017 When the window count reaches 2**LOG2_AVG, the FSM SHALL go to REPORT.
REQ-018 On entering REPORT, q_measured SHALL be set to accumulator>>LOG2_AVG (truncating) and ready SHALL be high for exactly that cycle.
REQ-019 The next state after REPORT SHALL be MEASURE with accumulator, window count and sample count cleared.
REQ-020 Latency: ready SHALL rise on the clk edge after the edge accepting the final sample.
REQ-021 q_measured SHALL hold its value between reports.
REQ-022 A registered copy of i_ref_setup SHALL be kept; any cycle where i_ref_setup differs from the copy SHALL force SETTLE, clear all counters and the accumulator, and suppress ready.
REQ-023 Rule REQ-022 SHALL take priority over window completion and REPORT in the same cycle.
REQ-024 sample_valid low SHALL freeze window and sample counters; in SETTLE, samples SHALL be ignored.
REQ-025 Counters SHALL wrap only via explicit clears, never by natural overflow.

Reset
REQ-026 rst high SHALL asynchronously set state SETTLE, clear all counters and the accumulator, and set q_measured=0, ready=0, overrange=0.
REQ-027 rst high SHALL load the i_ref_setup copy from the port, so no spurious restart occurs after release.
REQ-028 Reset asserted mid-window SHALL discard the partial measurement; no ready SHALL follow.

Configuration
REQ-029 With macro Q_METER_OVERRANGE_EN defined, overrange SHALL set when an accepted sample in MEASURE equals 0 or 2**WIDTH-1, and clear only on rst or REQ-022 restart.
REQ-030 With Q_METER_OVERRANGE_EN undefined, overrange SHALL be tied to 0 and no detection logic SHALL be built.

Structure
REQ-031 Package q_meter_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-032 Sub-module q_window_minmax SHALL hold per-window max/min tracking, with inputs sample, valid and start and outputs max and min.

Verification
REQ-033 Test 1: rst pulse -> q_measured=0, ready=0, overrange=0, state SETTLE.
REQ-034 Test 2: defaults, i_ref_setup constant, continuous valid alternating samples 100/400 -> single ready exactly 16+128+1 cycles after rst release, q_measured=300.
REQ-035 Test 3: same as Test 2, windows with p-p 300,301,302,302 -> q_measured=301 (sum 1205>>2, truncated).
REQ-036 Test 4: i_ref_setup changed 1023->973 at sample 70 of MEASURE -> no ready, SETTLE restarted; ready 145 cycles after the change.
REQ-037 Test 5: sample_valid high one cycle in three -> ready delayed to 16+384 cycles, same q_measured as Test 2.
REQ-038 Test 6 (Q_METER_OVERRANGE_EN): one sample of 1023 in MEASURE -> overrange=1, held until next restart; without the macro, overrange=0.

Source files
------------

// File: rtl/q_meter_pkg.sv
// Shared definitions for the Q meter: FSM state encoding, default parameter
// constants and a counter-width helper.
package q_meter_pkg;

  localparam int unsigned DEF_WIDTH         = 10;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_WIN_LEN       = 32;
  localparam int unsigned DEF_LOG2_AVG      = 2;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

  // Bits needed by a counter that runs 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/q_window_minmax.sv
// Per-window max/min tracker.
// Ports:
//   clk, rst        clock, async active-high reset
//   sample          unsigned sample
//   valid           sample is accepted this cycle
//   start           accepted sample is the first of a window (loads max and min)
//   max, min        registered extremes of the accepted samples of the window
module q_window_minmax
  import q_meter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             valid,
  input  logic             start,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] min
);

  // Extreme tracking; a window start overwrites both extremes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max <= '0;
      min <= '0;
    end else if (valid) begin
      if (start) begin
        max <= sample;
        min <= sample;
      end else begin
        if (sample > max) max <= sample;
        if (sample < min) min <= sample;
      end
    end
  end

endmodule

// File: rtl/q_meter.sv
// Oscillator quality meter: after every bias change, waits for the loop to
// settle, then measures peak-to-peak amplitude over fixed-length windows and
// reports the average of 2**LOG2_AVG windows.
// Ports:
//   clk, rst        clock, async active-high reset
//   sample          unsigned amplitude sample, accepted while sample_valid
//   sample_valid    sample qualifier
//   i_ref_setup     bias code; any change restarts settling
//   q_measured      averaged peak-to-peak amplitude (held between reports)
//   ready           one-cycle pulse when q_measured is updated
//   overrange       sticky clip flag
// Build option: define Q_METER_OVERRANGE_EN to build clip detection;
// otherwise overrange is tied low.
module q_meter
  import q_meter_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned WIN_LEN       = DEF_WIN_LEN,
  parameter int unsigned LOG2_AVG      = DEF_LOG2_AVG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] i_ref_setup,
  output logic [WIDTH-1:0] q_measured,
  output logic             ready,
  output logic             overrange
);

  localparam int unsigned ACC_W = WIDTH + LOG2_AVG;
  localparam int unsigned N_WIN = 1 << LOG2_AVG;
  localparam int unsigned SET_W = cnt_width(SETTLE_CYCLES);
  localparam int unsigned SMP_W = cnt_width(WIN_LEN);
  localparam int unsigned WIN_W = cnt_width(N_WIN);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ref_q;
  logic [SET_W-1:0]   settle_cnt_q;
  logic [SMP_W-1:0]   smp_cnt_q;
  logic [WIN_W-1:0]   win_cnt_q;
  logic [ACC_W-1:0]   acc_q;
  logic [WIDTH-1:0]   win_max, win_min;

  logic               restart_c;
  logic               accept_c;
  logic               win_start_c;
  logic               last_smp_c;
  logic               last_win_c;
  logic               settle_done_c;
  logic [WIDTH-1:0]   cur_max_c, cur_min_c, pp_c;

  // Bias tracking: a mismatch against the stored copy restarts everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ref_q <= i_ref_setup;
    else     ref_q <= i_ref_setup;
  end

  assign restart_c     = (i_ref_setup != ref_q);
  assign accept_c      = (state_q == ST_MEASURE) && sample_valid && !restart_c;
  assign win_start_c   = (smp_cnt_q == '0);
  assign last_smp_c    = accept_c && (smp_cnt_q == SMP_W'(WIN_LEN - 1));
  assign last_win_c    = (win_cnt_q == WIN_W'(N_WIN - 1));
  assign settle_done_c = (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));

  // Window extremes including the sample being accepted now, so the final
  // sample of a window lands in the accumulator on its own edge.
  assign cur_max_c = win_start_c ? sample : ((sample > win_max) ? sample : win_max);
  assign cur_min_c = win_start_c ? sample : ((sample < win_min) ? sample : win_min);
  assign pp_c      = cur_max_c - cur_min_c;

  q_window_minmax #(
    .WIDTH (WIDTH)
  ) u_minmax (
    .clk    (clk),
    .rst    (rst),
    .sample (sample),
    .valid  (accept_c),
    .start  (win_start_c),
    .max    (win_max),
    .min    (win_min)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_SETTLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a bias change overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (restart_c) begin
      state_d = ST_SETTLE;
    end else begin
      case (state_q)
        ST_SETTLE:  if (settle_done_c) state_d = ST_MEASURE;
        ST_MEASURE: if (last_smp_c && last_win_c) state_d = ST_REPORT;
        ST_REPORT:  state_d = ST_MEASURE;
        default:    state_d = ST_SETTLE;
      endcase
    end
  end

  // Counters, accumulator and report outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt_q <= '0;
      smp_cnt_q    <= '0;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      q_measured   <= '0;
      ready        <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (restart_c) begin
        settle_cnt_q <= '0;
        smp_cnt_q    <= '0;
        win_cnt_q    <= '0;
        acc_q        <= '0;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            settle_cnt_q <= settle_done_c ? '0 : settle_cnt_q + SET_W'(1);
          end
          ST_MEASURE: begin
            if (accept_c) begin
              if (last_smp_c) begin
                smp_cnt_q <= '0;
                acc_q     <= acc_q + ACC_W'(pp_c);
                win_cnt_q <= last_win_c ? '0 : win_cnt_q + WIN_W'(1);
              end else begin
                smp_cnt_q <= smp_cnt_q + SMP_W'(1);
              end
            end
          end
          ST_REPORT: begin
            q_measured <= WIDTH'(acc_q >> LOG2_AVG);
            ready      <= 1'b1;
            acc_q      <= '0;
            smp_cnt_q  <= '0;
            win_cnt_q  <= '0;
          end
          default: begin
            settle_cnt_q <= '0;
          end
        endcase
      end
    end
  end

`ifdef Q_METER_OVERRANGE_EN
  localparam logic [WIDTH-1:0] SAMPLE_FULL = {WIDTH{1'b1}};

  // Sticky clip flag; only a reset or a bias restart clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrange <= 1'b0;
    end else if (restart_c) begin
      overrange <= 1'b0;
    end else if (accept_c && ((sample == '0) || (sample == SAMPLE_FULL))) begin
      overrange <= 1'b1;
    end
  end
`else
  assign overrange = 1'b0;
`endif

endmodule

// File: tb/tb_q_meter.sv
module tb_q_meter;
  import q_meter_pkg::*;

`ifdef Q_METER_OVERRANGE_EN
  localparam int OVR_EN = 1;
`else
  localparam int OVR_EN = 0;
`endif

  localparam int SETTLE = 16;
  localparam int WLEN   = 32;
  localparam int NWIN   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sample;
  logic       sample_valid;
  logic [9:0] i_ref_setup;
  logic [9:0] q_measured;
  logic       ready;
  logic       overrange;

  q_meter dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .i_ref_setup  (i_ref_setup),
    .q_measured   (q_measured),
    .ready        (ready),
    .overrange    (overrange)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (behavioural, queue based) -------------
  int m_settled;          // settle cycles elapsed since last (re)start
  bit m_measuring;
  bit m_report_due;
  int m_win[$];           // samples of the open window
  int m_pp[$];            // peak-to-peak of completed windows
  int m_ref;
  int m_q;
  int m_ready;
  int m_ovr;

  task automatic model_reset();
    m_settled = 0; m_measuring = 0; m_report_due = 0;
    m_win.delete(); m_pp.delete();
    m_ref = int'(i_ref_setup);
    m_q = 0; m_ready = 0; m_ovr = 0;
  endtask

  // Predicts the visible outputs after the coming rising edge.
  task automatic model_edge();
    int mx, mn, sum;
    m_ready = 0;
    if (int'(i_ref_setup) != m_ref) begin
      m_ref = int'(i_ref_setup);
      m_settled = 0; m_measuring = 0; m_report_due = 0;
      m_win.delete(); m_pp.delete();
      m_ovr = 0;
      return;
    end
    if (m_report_due) begin
      sum = 0;
      foreach (m_pp[i]) sum += m_pp[i];
      m_q = sum / NWIN;
      m_ready = 1;
      m_report_due = 0;
      m_pp.delete();
    end else if (!m_measuring) begin
      m_settled++;
      if (m_settled == SETTLE) m_measuring = 1;
    end else if (sample_valid) begin
      if (OVR_EN != 0 && (sample == 10'd0 || sample == 10'd1023)) m_ovr = 1;
      m_win.push_back(int'(sample));
      if (m_win.size() == WLEN) begin
        mx = 0; mn = 1023;
        foreach (m_win[i]) begin
          if (m_win[i] > mx) mx = m_win[i];
          if (m_win[i] < mn) mn = m_win[i];
        end
        m_pp.push_back(mx - mn);
        m_win.delete();
        if (m_pp.size() == NWIN) m_report_due = 1;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int mode;               // 0 alt 100/400, 1 stepped p-p, 2 valid 1-in-3, 3 random
  int cyc;                // edges since reset release
  int first_ready;
  int q_at_ready;
  int ref_change_edge;
  int ref_change_val;
  int clip_edge;
  int n_reports;
  int ext[4] = '{0, 1, 2, 2};

  task automatic drive();
    int n, r;
    n = cyc + 1;
    if (n == ref_change_edge) i_ref_setup = 10'(ref_change_val);
    case (mode)
      0: begin sample_valid = 1'b1; sample = (n % 2 == 1) ? 10'd400 : 10'd100; end
      1: begin
        sample_valid = 1'b1;
        if (n % 2 == 0)  sample = 10'd100;
        else if (n >= 17) sample = 10'(400 + ext[((n - 17) / WLEN) % 4]);
        else             sample = 10'd400;
      end
      2: begin sample_valid = (n % 3 == 0); sample = (n % 2 == 1) ? 10'd400 : 10'd100; end
      default: begin
        sample_valid = ($urandom_range(0, 9) < 7);
        r = $urandom_range(0, 63);
        if (r == 0)      sample = 10'd0;
        else if (r == 1) sample = 10'd1023;
        else             sample = 10'($urandom_range(1, 1022));
        if ($urandom_range(0, 599) == 0) i_ref_setup = 10'($urandom_range(0, 1023));
      end
    endcase
    if (n == clip_edge) sample = 10'd1023;
  endtask

  task automatic tick();
    drive();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_eq("ready", int'(ready), m_ready);
    check_eq("q_measured", int'(q_measured), m_q);
    check_eq("overrange", int'(overrange), m_ovr);
    if (ready) n_reports++;
    if (ready && first_ready < 0) begin
      first_ready = cyc;
      q_at_ready = int'(q_measured);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("rst_q_measured", int'(q_measured), 0);
    check_eq("rst_ready", int'(ready), 0);
    check_eq("rst_overrange", int'(overrange), 0);
    check_eq("rst_state", int'(dut.state_q), int'(ST_SETTLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    first_ready = -1;
    q_at_ready = -1;
    ref_change_edge = 0;
    clip_edge = 0;
  endtask

  task automatic run_until_ready(input int budget);
    for (int i = 0; i < budget && first_ready < 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    rst = 1'b0; sample = '0; sample_valid = 1'b0; i_ref_setup = 10'd512;
    mode = 0; n_reports = 0;

    // Reset state and plain alternating amplitude.
    do_reset();
    mode = 0;
    run_until_ready(300);
    check_eq("t2_ready_cycle", first_ready, SETTLE + 128 + 1);
    check_eq("t2_q", q_at_ready, 300);

    // Windows with p-p 300,301,302,302 -> truncated average 301.
    do_reset();
    mode = 1;
    run_until_ready(300);
    check_eq("t3_ready_cycle", first_ready, 145);
    check_eq("t3_q", q_at_ready, 301);

    // Bias change at the 70th measured sample restarts settling.
    i_ref_setup = 10'd1023;
    do_reset();
    mode = 0;
    ref_change_edge = SETTLE + 70 + 1;
    ref_change_val  = 973;
    run_until_ready(400);
    check_eq("t4_ready_cycle", first_ready, SETTLE + 70 + 1 + 145);
    check_eq("t4_q", q_at_ready, 300);

    // Sparse valid, one cycle in three.
    do_reset();
    mode = 2;
    run_until_ready(600);
    check_eq("t5_ready_cycle", first_ready, SETTLE + 384);
    check_eq("t5_q", q_at_ready, 300);

    // Clip sample in MEASURE, held until a bias restart.
    do_reset();
    mode = 0;
    clip_edge = 30;
    for (int i = 0; i < 30; i++) tick();
    check_eq("t6_ovr_set", int'(overrange), OVR_EN);
    for (int i = 0; i < 40; i++) tick();
    check_eq("t6_ovr_held", int'(overrange), OVR_EN);
    ref_change_edge = cyc + 1;
    ref_change_val  = 200;
    tick();
    check_eq("t6_ovr_cleared", int'(overrange), 0);

    // Reset mid-window discards the partial measurement.
    do_reset();
    mode = 0;
    for (int i = 0; i < 80; i++) tick();
    do_reset();
    for (int i = 0; i < 120; i++) tick();
    check_eq("t7_no_ready", first_ready, -1);

    // Random samples, valid and occasional bias changes.
    do_reset();
    mode = 3;
    n_reports = 0;
    for (int i = 0; i < 3000; i++) tick();
    check_eq("rand_reports_seen", int'(n_reports > 0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
